// File: rtl/ahb_sram_ctrl.sv
// ahb_sram_ctrl: AHB-Lite slave in front of four 8-bit-wide SRAM lanes.
// Reads are issued straight from the address phase, so they run with zero
// wait states. A write holds the SRAM port during its data phase, so a read
// that arrives behind a write waits one cycle (state S_RDW).
// Optional feature macro: AHB_SRAM_ERR_EN. When it is defined, misaligned or
// oversized transfers get a two-cycle ERROR response and no SRAM access.
module ahb_sram_ctrl #(
    parameter int SRAM_AW = 13
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic               hsel,
    input  logic [31:0]        haddr,
    input  logic [1:0]         htrans,
    input  logic               hwrite,
    input  logic [2:0]         hsize,
    input  logic [31:0]        hwdata,
    input  logic               hready,
    output logic               hreadyout,
    output logic               hresp,
    output logic [31:0]        hrdata,
    output logic [SRAM_AW-1:0] sram_a,
    output logic [31:0]        sram_d,
    output logic [3:0]         sram_cen,
    output logic [3:0]         sram_wen,
    output logic               sram_oen,
    input  logic [31:0]        sram_q
);

`ifdef AHB_SRAM_ERR_EN
    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RDW, S_ERR1, S_ERR2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RDW} state_t;
`endif

    state_t             state_q, state_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [3:0]         mask_q, mask_d;
    logic               hreadyout_q, hreadyout_d;
    logic               addr_valid;
    logic               rd_issue;
    logic [3:0]         lane_mask;
    logic               unused_bits;

    // High address bits wrap and htrans[0] (SEQ vs NONSEQ) needs no special handling.
    assign unused_bits = ^{haddr[31:SRAM_AW+2], htrans[0]};

    assign addr_valid = hsel & hready & htrans[1];
    assign hrdata     = sram_q;
    assign hreadyout  = hreadyout_q;
    assign sram_oen   = ~hresetn;

    // Byte-lane mask of the transfer in its address phase.
    always_comb begin
        lane_mask = 4'b1111;
        case (hsize)
            3'd0:    lane_mask = 4'b0001 << haddr[1:0];
            3'd1:    lane_mask = haddr[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    end

`ifdef AHB_SRAM_ERR_EN
    logic hresp_q, hresp_d;
    logic xfer_err;

    // Misaligned half/word transfers and sizes above a word are rejected.
    always_comb begin
        xfer_err = (hsize > 3'd2)
                 | ((hsize == 3'd1) & haddr[0])
                 | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));
    end

    assign hresp = hresp_q;
`else
    logic xfer_err;

    assign xfer_err = 1'b0;
    assign hresp    = 1'b0;
`endif

    // Next-state logic: accept an address phase unless this slave is stalling.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        mask_d   = mask_q;
        rd_issue = 1'b0;
        case (state_q)
            S_RDW: state_d = S_RD;
`ifdef AHB_SRAM_ERR_EN
            S_ERR1: state_d = S_ERR2;
`endif
            default: begin
                if (hready) begin
                    if (!addr_valid) begin
                        state_d = S_IDLE;
                    end else if (xfer_err) begin
`ifdef AHB_SRAM_ERR_EN
                        state_d = S_ERR1;
`else
                        state_d = S_IDLE;
`endif
                    end else if (hwrite) begin
                        state_d = S_WR;
                        addr_d  = haddr[SRAM_AW+1:2];
                        mask_d  = lane_mask;
                    end else if (state_q == S_WR) begin
                        state_d = S_RDW;
                        addr_d  = haddr[SRAM_AW+1:2];
                    end else begin
                        state_d  = S_RD;
                        rd_issue = 1'b1;
                    end
                end
            end
        endcase
    end

    // Registered bus response derived from the state being entered.
    always_comb begin
        hreadyout_d = (state_d != S_RDW);
`ifdef AHB_SRAM_ERR_EN
        hreadyout_d = (state_d != S_RDW) && (state_d != S_ERR1);
        hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
`endif
    end

    // SRAM strobes: write in WR, delayed read in RDW, direct read otherwise.
    always_comb begin
        sram_cen = 4'hF;
        sram_wen = 4'hF;
        sram_a   = addr_q;
        sram_d   = 32'h0;
        if (hresetn) begin
            if (state_q == S_WR) begin
                sram_cen = ~mask_q;
                sram_wen = ~mask_q;
                sram_d   = hwdata;
            end else if (state_q == S_RDW) begin
                sram_cen = 4'h0;
            end else if (rd_issue) begin
                sram_cen = 4'h0;
                sram_a   = haddr[SRAM_AW+1:2];
            end
        end
    end

    // State and registered outputs; reset drops any pending write or read.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            mask_q      <= 4'h0;
            hreadyout_q <= 1'b1;
`ifdef AHB_SRAM_ERR_EN
            hresp_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            hreadyout_q <= hreadyout_d;
`ifdef AHB_SRAM_ERR_EN
            hresp_q     <= hresp_d;
`endif
        end
    end

endmodule

// File: doc/ahb_sram_ctrl.md
# ahb_sram_ctrl

AHB-Lite slave controller that sits directly upstream of four 8K×8 `sram` macros, one per byte lane, giving a 32 KB, 32-bit-wide zero-wait-state memory. It turns AHB address/data-phase transfers into single-cycle SRAM strobes, with byte/halfword/word write masking. A read issued directly behind a write gets one wait state, because the write holds the shared SRAM port.

## Interface
- `SRAM_AW`, 13: SRAM macro address width. Byte address span is 2^(SRAM_AW+2).
- `hclk` in 1: system clock; all state on rising edge.
- `hresetn` in 1: asynchronous active-low reset.
- `hsel` in 1: slave select.
- `haddr` in 32: byte address; bits [SRAM_AW+1:0] used.
- `htrans` in 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `hwrite` in 1: 1 = write.
- `hsize` in 3: 0 = byte, 1 = half, 2 = word.
- `hwdata` in 32: write data (data phase).
- `hready` in 1: bus ready; an address phase is sampled only when high.
- `hreadyout` out 1: slave ready.
- `hresp` out 1: 0 = OKAY, 1 = ERROR.
- `hrdata` out 32: read data = `sram_q` (combinational passthrough).
- `sram_a` out SRAM_AW: word address, shared by all lanes.
- `sram_d` out 32: lane n drives bits [8n+7:8n].
- `sram_cen` out 4: per-lane chip enable, active low.
- `sram_wen` out 4: per-lane write enable, active low.
- `sram_oen` out 1: output enable to all lanes. Tied 0 outside reset, 1 in reset.
- `sram_q` in 32: concatenated lane Q outputs.

## Operation
- Valid address phase: `hsel & hready & htrans[1]`. IDLE/BUSY get a zero-wait OKAY and cause no SRAM access.
- Lane mask:
  - byte: `1<<haddr[1:0]`
  - half: `haddr[1] ? 4'b1100 : 4'b0011`
  - word: `4'b1111`
- FSM states: IDLE, WR, RD, RDW (plus ERR1, ERR2; see Configuration).
- Read, no write in flight:
  - Issued combinationally in the address phase: `sram_cen=4'h0`, `sram_wen=4'hF`, `sram_a=haddr[SRAM_AW+1:2]`.
  - Next state is RD. The data phase has `hreadyout=1` and `hrdata=sram_q`.
- Write:
  - The address phase registers address and mask; next state is WR.
  - In WR: `sram_cen=~mask`, `sram_wen=~mask`, `sram_d=hwdata`, `sram_a`=registered address. Data commits at the WR→next edge, with `hreadyout=1`.
- Read address phase during WR (port conflict):
  - The read address is registered and the next state is RDW.
  - RDW: `hreadyout=0`; issue the read from the registered address; next state is RD.
- Back-to-back cases:
  - Write after read: no conflict, zero wait.
  - Read after read: pipelined, zero wait. Q updates after the edge at which the master samples `hrdata`.
- Any state with no new valid address phase returns to IDLE. Idle strobes: `sram_cen=4'hF`, `sram_wen=4'hF`.
- Unused `haddr` high bits are ignored (address wraps).

## Timing
- Reset values:
  - state IDLE, `hreadyout=1`, `hresp=0`
  - `sram_cen=4'hF`, `sram_wen=4'hF`, `sram_oen=1`
  - `sram_a` and `sram_d` registers cleared to 0
- Read latency: data valid in the cycle after the address phase (0 wait). After a write: 1 wait.
- Write latency: SRAM updated at the end of the data phase; a read in the following address phase returns the new value.
- While `hresetn` is low, all SRAM strobes are forced inactive, whatever the AHB inputs.
- Reset asserted mid-operation: any pending WR/RDW is dropped. Only a write whose WR edge already occurred is in memory.
- `hready` low in a data phase that this slave is not stalling: state holds, no new address phase is taken.

## Configuration
- `AHB_SRAM_ERR_EN` defined:
  - Triggers: `hsize>2`, half with `haddr[0]=1`, or word with `haddr[1:0]!=0`.
  - Response: no SRAM access and a two-cycle ERROR. ERR1: `hresp=1`, `hreadyout=0`. ERR2: `hresp=1`, `hreadyout=1`. Then IDLE or the next transfer.
- Not defined:
  - ERR states are absent and `hresp` is constant 0.
  - Misaligned low bits are ignored per the mask rules; `hsize>2` is treated as word.

## Test plan
- Reset: hold `hresetn=0` with NONSEQ reads driven → `sram_cen=4'hF`, `hreadyout=1`, `hresp=0`, no SRAM access.
- Word write then read: write 0xDEADBEEF to 0x0010, then NONSEQ read of 0x0010 → one wait cycle, `hrdata=0xDEADBEEF`.
- Byte lanes: word 0x11223344 at 0x0020, then byte write 0xAA to 0x0022 and half write 0xBBCC to 0x0020 → read returns 0x11AABBCC; `sram_wen` seen as 4'b1011 and 4'b1100.
- Pipelined reads: 4 SEQ reads 0x0100–0x010C of preloaded 1,2,3,4 → four consecutive zero-wait data phases returning 1,2,3,4.
- Wrap/top: write 0x5A5A5A5A to 0x7FFC → read 0x7FFC and alias 0xFFFC both return 0x5A5A5A5A.
- With `AHB_SRAM_ERR_EN`: half write to 0x0031 → ERROR pattern (`hreadyout` 0 then 1, `hresp=1` both cycles), memory at 0x0030 unchanged. Without the macro: same write updates lanes 0–1.
